cache_ctrl_2way: RTL
====================

Name: cache_ctrl_2way

Overview:
- Parametrised successor to the direct-address cache controller.
- Embeds its own 2-way set-associative, write-through, no-write-allocate cache with per-set LRU, a flush command and saturating hit/miss counters.
- Sits between the MEM stage and the SRAM controller. Each SRAM access returns one line of two 32-bit words.
- Cacheable space starts at BASE_ADDR; lower addresses bypass the cache.

Parameters:
ADDR_W, 32, request/SRAM address width
DATA_W, 32, word width; line = 2*DATA_W
SETS, 64, sets per way (power of 2, >=2); IDX_W = log2(SETS)
BASE_ADDR, 1024, first cacheable byte address
CNT_W, 32, width of hit/miss counters

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous active-high reset
address  in  ADDR_W  byte address from MEM stage, held stable until ready
wdata  in  DATA_W  store data
MEM_R_EN  in  1  load request, held until ready
MEM_W_EN  in  1  store request, held until ready
flush  in  1  one-cycle pulse: invalidate whole cache
rdata  out  DATA_W  load data, valid when ready && MEM_R_EN
ready  out  1  request completes this cycle
sram_address  out  ADDR_W  SRAM address
sram_wdata  out  DATA_W  SRAM store data
sram_r_en  out  1  SRAM read request
sram_w_en  out  1  SRAM write request
sram_ready  in  1  SRAM access done (1-cycle pulse)
sram_rdata  in  2*DATA_W  SRAM line, valid with sram_ready
hit_count  out  CNT_W  saturating cacheable-load hit counter
miss_count  out  CNT_W  saturating cacheable-load miss counter

Behaviour:
- Address split: off = address - BASE_ADDR; word = off[2]; idx = off[3 +: IDX_W]; tag = off[ADDR_W-1 : 3+IDX_W].
- Cacheable iff address >= BASE_ADDR (unsigned).
- Storage per set: valid[2], tag[2], line[2], lru (lru = way to replace next).
- Hit = cacheable && valid[w] && tag[w]==tag for some w. Both ways matching cannot occur.
- FSM states: IDLE, RD_MISS, WR_THRU, FLUSH.
  - IDLE, flush=1: go to FLUSH. Flush has priority; ready=0.
  - IDLE, MEM_W_EN: go to WR_THRU. Stores win if both enables are high.
  - IDLE, MEM_R_EN && hit: ready=1 same cycle (0-cycle latency); rdata = selected word of the hit way; lru <= ~hit_way; hit_count++.
  - IDLE, MEM_R_EN && !hit: go to RD_MISS; miss_count++. Uncached loads count neither hits nor misses.
  - RD_MISS: sram_r_en=1, sram_address=address. On sram_ready: ready=1; rdata = sram_rdata half selected by off[2] (raw address[2] if uncached). If cacheable, write way lru of set idx (valid=1, tag, line=sram_rdata) and set lru <= ~lru. Next state IDLE.
  - WR_THRU: sram_w_en=1, sram_address=address, sram_wdata=wdata. On sram_ready: ready=1. If store hits, overwrite that word in the hit way and set lru <= ~hit_way. On miss, no allocate. Next state IDLE.
  - FLUSH: clear all valid bits (one cycle, register-array reset; lru untouched), then IDLE. A flush pulse outside IDLE is latched in a pending bit and serviced on the next IDLE cycle, before any new request.
- Hit evaluation in IDLE uses state as of that cycle. A fill and a load to the same set in consecutive cycles therefore sees the fill.
- Counters saturate at all-ones and never wrap.
- Outputs when inactive: rdata=0, sram_address=0, sram_wdata=0, sram_r_en=0, sram_w_en=0, ready=0.
- sram_ready outside RD_MISS/WR_THRU is ignored.
- Reset (async, any state): state=IDLE, all valid=0, lru=0, pending flush=0, counters=0, all outputs 0. An SRAM access in flight at reset is abandoned; its late sram_ready is ignored.

Test Plan:
- After reset, load 0x400 (BASE_ADDR): RD_MISS; sram_r_en=1, sram_address=0x400. sram_ready with sram_rdata=0xBBBB_BBBB_AAAA_AAAA -> ready=1, rdata=0xAAAA_AAAA, miss_count=1. Repeat load 0x404 -> same-cycle ready, rdata=0xBBBB_BBBB, hit_count=1.
- LRU: fill 0x400 (way0) and 0x600 (same idx, way1), then load 0x400 (hit), then miss on 0x800 -> replaces way1. Subsequent 0x400 hits; 0x600 misses.
- Store 0x404 data 0x1234_5678 after 0x400 cached: sram_w_en=1 until sram_ready. Reload 0x404 hits with 0x1234_5678. Store to uncached set then load -> miss (no allocate).
- Load 0x100 (below base): SRAM read, ready on sram_ready, no fill, counters unchanged. Second load of 0x100 misses again.
- flush pulsed during RD_MISS: fill completes, then FLUSH executes. Next load of the previously cached address misses.
- Assert rst mid-RD_MISS: outputs 0 immediately, state IDLE. Stray sram_ready afterwards gives no ready and no fill. Counters 0.

Source files
------------

// File: rtl/cache_ctrl_2way.sv
// -----------------------------------------------------------------------------
// cache_ctrl_2way
//
// Cache controller between the MEM stage and the SRAM controller. It embeds a
// 2-way set-associative, write-through, no-write-allocate cache with per-set
// LRU replacement, a whole-cache flush command and saturating hit/miss
// counters. Each SRAM access moves one line of two DATA_W words. Addresses
// below BASE_ADDR bypass the cache entirely.
//
// Handshake: the MEM stage raises MEM_R_EN or MEM_W_EN and holds address/wdata
// stable until ready=1 for one cycle; the request completes in that cycle.
// Toward SRAM, sram_r_en/sram_w_en stay high until sram_ready pulses for one
// cycle, which completes the access; sram_ready at any other time is ignored.
//
// Ports:
//   clk, rst          clock (rising edge), asynchronous active-high reset
//   address, wdata    MEM-stage byte address and store data
//   MEM_R_EN/MEM_W_EN load/store requests (store wins if both are high)
//   flush             one-cycle pulse: invalidate the whole cache
//   rdata, ready      load data (valid with ready && MEM_R_EN), completion
//   sram_*            SRAM request/response interface (line-wide read data)
//   hit_count         saturating count of cacheable load hits
//   miss_count        saturating count of cacheable load misses
// -----------------------------------------------------------------------------
module cache_ctrl_2way #(
  parameter int          ADDR_W    = 32,
  parameter int          DATA_W    = 32,
  parameter int          SETS      = 64,
  parameter int unsigned BASE_ADDR = 1024,
  parameter int          CNT_W     = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [ADDR_W-1:0]   address,
  input  logic [DATA_W-1:0]   wdata,
  input  logic                MEM_R_EN,
  input  logic                MEM_W_EN,
  input  logic                flush,
  output logic [DATA_W-1:0]   rdata,
  output logic                ready,
  output logic [ADDR_W-1:0]   sram_address,
  output logic [DATA_W-1:0]   sram_wdata,
  output logic                sram_r_en,
  output logic                sram_w_en,
  input  logic                sram_ready,
  input  logic [2*DATA_W-1:0] sram_rdata,
  output logic [CNT_W-1:0]    hit_count,
  output logic [CNT_W-1:0]    miss_count
);

  localparam int IDX_W = $clog2(SETS);
  localparam int TAG_W = ADDR_W - 3 - IDX_W;
  localparam logic [ADDR_W-1:0] BASE = ADDR_W'(BASE_ADDR);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_MISS = 2'd1,
    WR_THRU = 2'd2,
    FLUSH   = 2'd3
  } state_t;

  state_t state;
  logic   flush_pend;

  // Cache storage. Valid and LRU bits live in flat vectors so a flush can
  // clear every valid bit in one cycle; tags and lines need no reset.
  logic [SETS-1:0]     valid0;
  logic [SETS-1:0]     valid1;
  logic [SETS-1:0]     lru;       // way to replace next in each set
  logic [TAG_W-1:0]    tag0  [SETS];
  logic [TAG_W-1:0]    tag1  [SETS];
  logic [2*DATA_W-1:0] line0 [SETS];
  logic [2*DATA_W-1:0] line1 [SETS];

  // Address decode relative to the start of cacheable space.
  logic [ADDR_W-1:0] off;
  logic              word_sel;
  logic [IDX_W-1:0]  idx;
  logic [TAG_W-1:0]  tag;
  logic              cacheable;
  logic              unused_off_lsb;

  assign off            = address - BASE;
  assign word_sel       = off[2];
  assign idx            = off[3 +: IDX_W];
  assign tag            = off[ADDR_W-1 -: TAG_W];
  assign cacheable      = (address >= BASE);
  assign unused_off_lsb = ^off[1:0];

  // Lookup against the current contents; a fill written last cycle is visible.
  logic                hit0;
  logic                hit1;
  logic                hit;
  logic                hit_way;
  logic [2*DATA_W-1:0] hit_line;
  logic                rd_sel;

  assign hit0     = cacheable && valid0[idx] && (tag0[idx] == tag);
  assign hit1     = cacheable && valid1[idx] && (tag1[idx] == tag);
  assign hit      = hit0 || hit1;
  assign hit_way  = hit1;
  assign hit_line = hit1 ? line1[idx] : line0[idx];
  // Uncached loads pick the half by the raw address instead of the offset.
  assign rd_sel   = cacheable ? off[2] : address[2];

  // A flush (new pulse or one remembered from a busy cycle) pre-empts any
  // request waiting in IDLE.
  logic start_flush;
  logic idle_hit;
  logic fill_en;
  logic wr_upd;

  assign start_flush = flush || flush_pend;
  assign idle_hit    = (state == IDLE) && !start_flush && !MEM_W_EN &&
                       MEM_R_EN && hit;
  assign fill_en     = (state == RD_MISS) && sram_ready && cacheable;
  assign wr_upd      = (state == WR_THRU) && sram_ready && hit;

  // ---------------------------------------------------------------------------
  // Control FSM, valid/LRU state and counters
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      flush_pend <= 1'b0;
      valid0     <= '0;
      valid1     <= '0;
      lru        <= '0;
      hit_count  <= '0;
      miss_count <= '0;
    end else begin
      if (flush && (state != IDLE)) begin
        flush_pend <= 1'b1;
      end

      case (state)
        IDLE: begin
          if (start_flush) begin
            state      <= FLUSH;
            flush_pend <= 1'b0;
          end else if (MEM_W_EN) begin
            state <= WR_THRU;
          end else if (MEM_R_EN) begin
            if (hit) begin
              lru[idx] <= ~hit_way;
              if (hit_count != {CNT_W{1'b1}}) begin
                hit_count <= hit_count + CNT_W'(1);
              end
            end else begin
              state <= RD_MISS;
              if (cacheable && (miss_count != {CNT_W{1'b1}})) begin
                miss_count <= miss_count + CNT_W'(1);
              end
            end
          end
        end

        RD_MISS: begin
          if (sram_ready) begin
            state <= IDLE;
            if (cacheable) begin
              if (lru[idx]) begin
                valid1[idx] <= 1'b1;
              end else begin
                valid0[idx] <= 1'b1;
              end
              lru[idx] <= ~lru[idx];
            end
          end
        end

        WR_THRU: begin
          if (sram_ready) begin
            state <= IDLE;
            if (hit) begin
              lru[idx] <= ~hit_way;
            end
          end
        end

        FLUSH: begin
          valid0 <= '0;
          valid1 <= '0;
          state  <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Tag and line storage. Writes are gated by FSM state, which reset forces to
  // IDLE, so an access abandoned by reset can never land here.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (fill_en) begin
      if (lru[idx]) begin
        tag1[idx]  <= tag;
        line1[idx] <= sram_rdata;
      end else begin
        tag0[idx]  <= tag;
        line0[idx] <= sram_rdata;
      end
    end
    if (wr_upd) begin
      if (hit_way) begin
        if (word_sel) line1[idx][2*DATA_W-1:DATA_W] <= wdata;
        else          line1[idx][DATA_W-1:0]        <= wdata;
      end else begin
        if (word_sel) line0[idx][2*DATA_W-1:DATA_W] <= wdata;
        else          line0[idx][DATA_W-1:0]        <= wdata;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs: decoded from the registered state; ready/rdata also follow the
  // same-cycle hit and sram_ready so hits and fills complete without delay.
  // ---------------------------------------------------------------------------
  always_comb begin
    rdata        = '0;
    ready        = 1'b0;
    sram_address = '0;
    sram_wdata   = '0;
    sram_r_en    = 1'b0;
    sram_w_en    = 1'b0;
    case (state)
      IDLE: begin
        if (idle_hit) begin
          ready = 1'b1;
          rdata = word_sel ? hit_line[2*DATA_W-1:DATA_W] : hit_line[DATA_W-1:0];
        end
      end
      RD_MISS: begin
        sram_r_en    = 1'b1;
        sram_address = address;
        if (sram_ready) begin
          ready = 1'b1;
          rdata = rd_sel ? sram_rdata[2*DATA_W-1:DATA_W] : sram_rdata[DATA_W-1:0];
        end
      end
      WR_THRU: begin
        sram_w_en    = 1'b1;
        sram_address = address;
        sram_wdata   = wdata;
        if (sram_ready) begin
          ready = 1'b1;
        end
      end
      default: ;
    endcase
  end

endmodule
